// File: rtl/n8_pkg.sv
// Shared types and constants for the N8 controller reader.
// Button indices follow the controller's shift order.
package n8_pkg;

    typedef enum logic [2:0] {
        ST_LATCH,
        ST_PULSE_HI,
        ST_PULSE_LO,
        ST_DONE,
        ST_IDLE
    } n8_state_t;

    localparam int N8_BUTTONS = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/n8_phase_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// Loading N-1 on state entry makes the state last exactly N cycles.
module n8_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/n8_serial_reader.sv
// Polls an N8 controller: drives latch/pulse, shifts in 8 active-low
// bits and publishes per-frame button levels and press events.
module n8_serial_reader
    import n8_pkg::*;
#(
    parameter int LATCH_CYCLES = 600,
    parameter int HALF_CYCLES  = 300,
    parameter int POLL_CYCLES  = 833333
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  data_in,
    output logic                  latch,
    output logic                  pulse,
    output logic [N8_BUTTONS-1:0] buttons,
    output logic [N8_BUTTONS-1:0] press,
    output logic                  up,
    output logic                  down,
    output logic                  select,
    output logic                  start,
    output logic                  frame_valid
);

    localparam int TMAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES
                                                       : HALF_CYCLES;
    localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

    localparam logic [TW-1:0] T_LATCH = TW'(LATCH_CYCLES - 1);
    localparam logic [TW-1:0] T_HALF  = TW'(HALF_CYCLES - 1);
    localparam logic [PW-1:0] P_LAST  = PW'(POLL_CYCLES - 1);

    n8_state_t             state;
    n8_state_t             state_nx;
    logic [2:0]            idx;
    logic [N8_BUTTONS-1:0] shift;
    logic [PW-1:0]         poll;
    logic                  t_load;
    logic [TW-1:0]         t_val;
    logic                  t_done;
    logic                  sample;

    assign sample = ~data_in;

    n8_phase_timer #(
        .W(TW)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (t_load),
        .load_val(t_val),
        .done    (t_done)
    );

    always_comb begin
        state_nx = state;
        t_load   = 1'b0;
        t_val    = T_HALF;
        unique case (state)
            ST_IDLE: begin
                if (poll == '0) begin
                    state_nx = ST_LATCH;
                    t_load   = 1'b1;
                    t_val    = T_LATCH;
                end
            end
            ST_LATCH: begin
                if (t_done) begin
                    state_nx = ST_PULSE_HI;
                    t_load   = 1'b1;
                end
            end
            ST_PULSE_HI: begin
                if (t_done) begin
                    state_nx = ST_PULSE_LO;
                    t_load   = 1'b1;
                end
            end
            ST_PULSE_LO: begin
                if (t_done) begin
                    if (idx == 3'd7) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx = ST_PULSE_HI;
                        t_load   = 1'b1;
                    end
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Reset parks in IDLE with poll=0, so the next edge starts a latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            idx     <= '0;
            shift   <= '0;
            poll    <= '0;
            buttons <= '0;
            press   <= '0;
        end else begin
            state <= state_nx;
            poll  <= (poll == P_LAST) ? '0 : poll + PW'(1);
            press <= '0;
            if (state == ST_LATCH && t_done) begin
                shift[0] <= sample;
                idx      <= 3'd1;
            end
            if (state == ST_PULSE_LO && t_done) begin
                shift[idx] <= sample;
                idx        <= idx + 3'd1;
                if (idx == 3'd7) begin
                    buttons <= {sample, shift[6:0]};
                    press   <= {sample, shift[6:0]} & ~buttons;
                end
            end
        end
    end

    assign latch       = (state == ST_LATCH);
    assign pulse       = (state == ST_PULSE_HI);
    assign frame_valid = (state == ST_DONE);

    assign up     = press[BTN_UP];
    assign down   = press[BTN_DOWN];
    assign select = press[BTN_SELECT];
    assign start  = press[BTN_START];

endmodule

// File: tb/tb_n8_serial_reader.sv
// Directed bench for n8_serial_reader with a behavioural controller
// model and a frame scoreboard.
module tb_n8_serial_reader;

    localparam int L = 4;
    localparam int H = 2;
    localparam int P = 64;

    typedef struct {
        logic [7:0] btn;
        logic [7:0] prs;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       data_in;
    logic       latch;
    logic       pulse;
    logic [7:0] buttons;
    logic [7:0] press;
    logic       up;
    logic       down;
    logic       select;
    logic       start;
    logic       frame_valid;

    logic [7:0] ctrl_btn = 8'h00;
    logic [7:0] msr = 8'h00;
    logic       pulse_d = 1'b0;

    exp_t       sb[$];
    int         rises[$];
    logic [7:0] model_prev;
    logic [7:0] held;
    logic       latch_d;
    int         cyc;
    int         n_cmp = 0;
    int         n_bad = 0;

    n8_serial_reader #(
        .LATCH_CYCLES(L),
        .HALF_CYCLES (H),
        .POLL_CYCLES (P)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .latch      (latch),
        .pulse      (pulse),
        .buttons    (buttons),
        .press      (press),
        .up         (up),
        .down       (down),
        .select     (select),
        .start      (start),
        .frame_valid(frame_valid)
    );

    always #5 clk = ~clk;

    // Controller: parallel load while latched, shift on pulse rise.
    always @(posedge clk) begin
        pulse_d <= pulse;
        if (latch) begin
            msr <= ctrl_btn;
        end else if (pulse && !pulse_d) begin
            msr <= {1'b0, msr[7:1]};
        end
    end

    assign data_in = ~msr[0];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_frame(input logic [7:0] btn);
        exp_t e;
        ctrl_btn   = btn;
        e.btn      = btn;
        e.prs      = btn & ~model_prev;
        model_prev = btn;
        sb.push_back(e);
    endtask

    task automatic run_frame(input int n);
        exp_t e;
        logic el;
        logic ep;
        for (int r = 1; r <= n; r++) begin
            @(posedge clk);
            #1;
            cyc++;
            el = (r <= L);
            ep = (r > L) && (r <= L + 14 * H) && (((r - L - 1) % (2 * H)) < H);
            chk("latch", 32'(latch), 32'(el));
            chk("pulse", 32'(pulse), 32'(ep));
            chk("overlap", 32'(latch & pulse), 32'd0);
            chk("frame_valid", 32'(frame_valid), 32'(r == L + 14 * H + 1));
            if (latch && !latch_d) rises.push_back(cyc);
            latch_d = latch;
            if (r == L + 14 * H + 1) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("buttons", 32'(buttons), 32'(e.btn));
                    chk("press", 32'(press), 32'(e.prs));
                    chk("up", 32'(up), 32'(e.prs[4]));
                    chk("down", 32'(down), 32'(e.prs[5]));
                    chk("select", 32'(select), 32'(e.prs[2]));
                    chk("start", 32'(start), 32'(e.prs[3]));
                    held = e.btn;
                end
            end else begin
                chk("buttons_hold", 32'(buttons), 32'(held));
                chk("press_idle",
                    32'({press, up, down, select, start}), 32'd0);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        model_prev = 8'h00;
        held       = 8'h00;
        latch_d    = 1'b0;
        cyc        = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("reset_outs",
                32'({latch, pulse, buttons, press, frame_valid,
                     up, down, select, start}), 32'd0);
        end

        drive_frame(8'h10);
        reset = 1'b0;
        run_frame(P);
        drive_frame(8'h10);
        run_frame(P);
        chk("period", 32'(rises[1] - rises[0]), 32'(P));
        drive_frame(8'h00);
        run_frame(P);
        drive_frame(8'h0C);
        run_frame(P);
        drive_frame(8'h81);
        run_frame(P);

        // Abort a frame during pulse 3 and check the restart.
        ctrl_btn = 8'h20;
        run_frame(L + 4 * H + 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        chk("abort_outs",
            32'({latch, pulse, buttons, press, frame_valid}), 32'd0);
        reset      = 1'b0;
        latch_d    = 1'b0;
        model_prev = 8'h00;
        held       = 8'h00;
        drive_frame(8'h10);
        run_frame(P);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
